ctrl_pipe_unit: RTL

- Pipelined successor to the combinational ARM decoder for the PPU.
- Decodes the ID-stage instruction and evaluates its condition field against the current NZCV flags.
- Detects load-use hazards, then carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers with stall-bubble and flush support.
- Sits between IF/ID and the datapath stage registers. Emits per-stage control plus a hazard stall for the PC and IF/ID.

---
 rtl/ctrl_pipe_unit_pkg.sv | 54 +++++
 rtl/ctrl_pipe_unit_if.sv | 27 ++
 rtl/ctrl_pipe_unit_decode_cond.sv | 55 +++++
 rtl/ctrl_pipe_unit.sv | 64 ++++++
 4 files changed

// File: rtl/ctrl_pipe_unit_pkg.sv
// arm_ctrl_pkg: control-bundle types, ALU/AM encodings and bubble constants for the ARM control pipeline
package arm_ctrl_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b1001;
  localparam logic [1:0] AM_IMM = 2'b00;
  localparam logic [1:0] AM_DEF = 2'b01;
  localparam logic [1:0] AM_LS_IMM = 2'b10;
  localparam logic [1:0] AM_REG = 2'b11;
  localparam logic [3:0] RD_LINK = 4'd14;
  // Indexed by data-processing opcode instr[24:21]; entry 15 (MVN) first
  localparam logic [15:0][3:0] ALU_MAP = {
    4'b1011, 4'b1100, 4'b1010, 4'b0111,
    4'b1001, 4'b1001, 4'b1001, 4'b1001,
    4'b0101, 4'b0011, 4'b0001, 4'b0000,
    4'b0100, 4'b0010, 4'b1000, 4'b0110
  };
  typedef struct packed {
    logic       valid;
    logic [3:0] alu_op;
    logic [1:0] am;
    logic       s;
    logic       load;
    logic       rf_en;
    logic       size;
    logic       rw;
    logic       e;
    logic       b;
    logic       bl;
    logic [3:0] rd;
  } ctrl_bundle_t;
  typedef struct packed {
    logic       valid;
    logic       load;
    logic       rf_en;
    logic       size;
    logic       rw;
    logic       e;
    logic [3:0] rd;
  } mem_ctrl_t;
  typedef struct packed {
    logic       valid;
    logic       load;
    logic       rf_en;
    logic [3:0] rd;
  } wb_ctrl_t;
  localparam ctrl_bundle_t BUBBLE = '{alu_op: ALU_NOP, am: AM_DEF, default: '0};
  function automatic mem_ctrl_t to_mem(ctrl_bundle_t c);
    return '{valid: c.valid, load: c.load, rf_en: c.rf_en, size: c.size, rw: c.rw, e: c.e, rd: c.rd};
  endfunction
  function automatic wb_ctrl_t to_wb(mem_ctrl_t m);
    return '{valid: m.valid, load: m.load, rf_en: m.rf_en, rd: m.rd};
  endfunction
endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ctrl_pipe_unit_if: ID-stage inputs and per-stage control outputs of the control pipeline
interface ctrl_pipe_unit_if #(parameter int RD_W = 4, parameter int OP_W = 4);
  logic [31:0]     instr_id;
  logic [3:0]      flags_in;
  logic            flush;
  logic            hazard_stall;
  logic            ex_valid, ex_s, ex_load, ex_rf_en, ex_size, ex_rw, ex_e, ex_b, ex_bl;
  logic [OP_W-1:0] ex_alu_op;
  logic [1:0]      ex_am;
  logic [RD_W-1:0] ex_rd;
  logic            mem_valid, mem_load, mem_rf_en, mem_size, mem_rw, mem_e;
  logic [RD_W-1:0] mem_rd;
  logic            wb_valid, wb_load, wb_rf_en;
  logic [RD_W-1:0] wb_rd;
  modport master (
    output instr_id, flags_in, flush,
    input  hazard_stall, ex_valid, ex_alu_op, ex_am, ex_s, ex_load, ex_rf_en, ex_size, ex_rw, ex_e,
           ex_b, ex_bl, ex_rd, mem_valid, mem_load, mem_rf_en, mem_size, mem_rw, mem_e, mem_rd,
           wb_valid, wb_load, wb_rf_en, wb_rd
  );
  modport slave (
    input  instr_id, flags_in, flush,
    output hazard_stall, ex_valid, ex_alu_op, ex_am, ex_s, ex_load, ex_rf_en, ex_size, ex_rw, ex_e,
           ex_b, ex_bl, ex_rd, mem_valid, mem_load, mem_rf_en, mem_size, mem_rw, mem_e, mem_rd,
           wb_valid, wb_load, wb_rf_en, wb_rd
  );
endinterface

// File: rtl/ctrl_pipe_unit_decode_cond.sv
// arm_decode_cond: combinational ARM control decode plus NZCV condition evaluation
module arm_decode_cond
  import arm_ctrl_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic [11:0]  hi_i,
  input  logic [3:0]   rd_i,
  input  logic [3:0]   flags_i,
  output ctrl_bundle_t ctrl_o,
  output logic         cond_pass_o
);
  logic [3:0] cond;
  logic [2:0] cls;
  logic [3:0] op;
  logic n, z, c, v, base;
  assign cond = hi_i[11:8];
  assign cls = hi_i[7:5];
  assign op = hi_i[4:1];
  assign {n, z, c, v} = flags_i;
  // Odd condition codes are the negation of the preceding even code; 1111 is the negation of AL
  assign base = cond[3:1] == 3'd0 ? z :
                cond[3:1] == 3'd1 ? c :
                cond[3:1] == 3'd2 ? n :
                cond[3:1] == 3'd3 ? v :
                cond[3:1] == 3'd4 ? (c && !z) :
                cond[3:1] == 3'd5 ? (n == v) :
                cond[3:1] == 3'd6 ? (!z && n == v) : 1'b1;
  assign cond_pass_o = !COND_EN || (base ^ cond[0]);
  always_comb begin
    ctrl_o = BUBBLE;
    ctrl_o.valid = 1'b1;
    if (cls[2:1] == 2'b00) begin
      ctrl_o.am = cls[0] ? AM_IMM : AM_REG;
      ctrl_o.s = hi_i[0];
      ctrl_o.alu_op = ALU_MAP[op];
      ctrl_o.rf_en = op[3:2] != 2'b10;
    end
    if (cls[2:1] == 2'b01) begin
      ctrl_o.am = cls[0] ? AM_REG : AM_LS_IMM;
      ctrl_o.alu_op = hi_i[3] ? ALU_ADD : ALU_SUB;
      ctrl_o.load = hi_i[0];
      ctrl_o.rw = !hi_i[0];
      ctrl_o.size = hi_i[2];
      ctrl_o.e = 1'b1;
      ctrl_o.rf_en = hi_i[0];
    end
    if (cls == 3'b101) begin
      ctrl_o.b = 1'b1;
      ctrl_o.bl = hi_i[4];
      ctrl_o.rf_en = hi_i[4];
    end
    ctrl_o.rd = ctrl_o.bl ? RD_LINK : rd_i;
  end
endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: load-use hazard detection and ID/EX, EX/MEM, MEM/WB control registers with bubble and flush
module ctrl_pipe_unit
  import arm_ctrl_pkg::*;
#(
  parameter bit COND_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int RD_W = 4,
  parameter int OP_W = 4
) (
  input logic             clk,
  input logic             reset,
  ctrl_pipe_unit_if.slave bus
);
  logic [31:0] ins;
  logic [2:0] cls;
  ctrl_bundle_t dec, ex_q, ex_d;
  mem_ctrl_t mem_q;
  wb_ctrl_t wb_q;
  logic cond_pass, src_match, hazard, bubble;
  assign ins = bus.instr_id;
  assign cls = ins[27:25];
  arm_decode_cond #(.COND_EN(COND_EN)) u_dec (
    .hi_i       (ins[31:20]),
    .rd_i       (ins[15:12]),
    .flags_i    (bus.flags_in),
    .ctrl_o     (dec),
    .cond_pass_o(cond_pass)
  );
  assign src_match = (!cls[2] && ex_q.rd == ins[19:16]) ||
                     ((cls == 3'b000 || cls == 3'b011) && ex_q.rd == ins[3:0]) ||
                     (cls[2:1] == 2'b01 && !ins[20] && ex_q.rd == ins[15:12]);
  assign hazard = HAZARD_EN && ex_q.valid && ex_q.load && src_match;
  assign bus.hazard_stall = hazard && !bus.flush && !reset;
  assign bubble = !cond_pass || ins == 32'h0 || hazard || bus.flush;
  assign ex_d = bubble ? BUBBLE : dec;
  always_ff @(posedge clk) begin
    ex_q <= reset ? BUBBLE : ex_d;
    mem_q <= reset ? to_mem(BUBBLE) : to_mem(ex_q);
    wb_q <= reset ? to_wb(to_mem(BUBBLE)) : to_wb(mem_q);
  end
  assign bus.ex_valid = ex_q.valid;
  assign bus.ex_alu_op = OP_W'(ex_q.alu_op);
  assign bus.ex_am = ex_q.am;
  assign bus.ex_s = ex_q.s;
  assign bus.ex_load = ex_q.load;
  assign bus.ex_rf_en = ex_q.rf_en;
  assign bus.ex_size = ex_q.size;
  assign bus.ex_rw = ex_q.rw;
  assign bus.ex_e = ex_q.e;
  assign bus.ex_b = ex_q.b;
  assign bus.ex_bl = ex_q.bl;
  assign bus.ex_rd = RD_W'(ex_q.rd);
  assign bus.mem_valid = mem_q.valid;
  assign bus.mem_load = mem_q.load;
  assign bus.mem_rf_en = mem_q.rf_en;
  assign bus.mem_size = mem_q.size;
  assign bus.mem_rw = mem_q.rw;
  assign bus.mem_e = mem_q.e;
  assign bus.mem_rd = RD_W'(mem_q.rd);
  assign bus.wb_valid = wb_q.valid;
  assign bus.wb_load = wb_q.load;
  assign bus.wb_rf_en = wb_q.rf_en;
  assign bus.wb_rd = RD_W'(wb_q.rd);
endmodule
